// File: rtl/i2s_pkg.sv
// i2s_pkg: shared constants, types and helpers for the i2s_master slice.
// Frame layout is {left[31:16], right[15:0]}, MSB launched in slot 1.
package i2s_pkg;

    localparam int FRAME_BITS     = 32;
    localparam int SAMPLE_BITS    = 16;
    localparam int SLOT_LEFT_MSB  = 1;
    localparam int SLOT_RIGHT_MSB = 17;
    localparam int SLOT_LAST      = 0;

    typedef logic [2*SAMPLE_BITS-1:0]      frame_t;
    typedef logic [$clog2(FRAME_BITS)-1:0] slot_t;

    typedef enum logic {
        CG_WAIT = 1'b0,
        CG_RUN  = 1'b1
    } cg_state_t;

    // lrclk is high for the right half, which starts one slot before its MSB
    function automatic logic slot_is_right(slot_t s);
        return s >= slot_t'(SLOT_RIGHT_MSB - 1);
    endfunction

endpackage

// File: rtl/i2s_if.sv
// i2s_if: word-level valid/ready bundle between i2s_master and its FIFOs.
// slave is the i2s_master side, master is the FIFO/producer side.
interface i2s_if;
    import i2s_pkg::*;

    frame_t tx_data;
    logic   tx_valid;
    logic   tx_ready;
    logic   tx_underrun;
    frame_t rx_data;
    logic   rx_valid;

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output tx_underrun,
        output rx_data,
        output rx_valid
    );

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  tx_underrun,
        input  rx_data,
        input  rx_valid
    );

endinterface

// File: rtl/i2s_clkgen.sv
// i2s_clkgen: BCLK divider, LRCLK and slot counter for i2s_master.
// rise/fall are registered one-cycle strobes aligned with the bclk edge.
module i2s_clkgen
    import i2s_pkg::*;
#(
    parameter int BCLK_DIV = 4
) (
    input  logic  bus_clk,
    input  logic  bus_rst_n,
    input  logic  enable,
    output logic  bclk,
    output logic  lrclk,
    output logic  rise,
    output logic  fall,
    output slot_t slot
);

    localparam int CW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(BCLK_DIV - 1);

    logic [CW-1:0] div_cnt;
    logic          tc;
    logic          fall_tc;
    cg_state_t     state_q;
    cg_state_t     state_d;
    slot_t         slot_d;

    assign tc      = (div_cnt == DIV_LAST);
    assign fall_tc = tc && bclk;

    // The first fall after enable enters slot 0 instead of advancing
    always_comb begin
        state_d = state_q;
        slot_d  = slot;
        unique case (state_q)
            CG_WAIT: begin
                if (fall_tc) begin
                    state_d = CG_RUN;
                    slot_d  = slot_t'(SLOT_LAST);
                end
            end
            CG_RUN: begin
                if (fall_tc) begin
                    slot_d = slot + 1'b1;
                end
            end
            default: ;
        endcase
        if (!enable) begin
            state_d = CG_WAIT;
            slot_d  = '0;
        end
    end

    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            state_q <= CG_WAIT;
            slot    <= '0;
            div_cnt <= '0;
            bclk    <= 1'b0;
            lrclk   <= 1'b1;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            state_q <= state_d;
            slot    <= slot_d;
            rise    <= enable && tc && !bclk;
            fall    <= enable && fall_tc;
            if (!enable) begin
                div_cnt <= '0;
                bclk    <= 1'b0;
                lrclk   <= 1'b1;
            end else if (tc) begin
                div_cnt <= '0;
                bclk    <= !bclk;
                if (bclk) begin
                    lrclk <= slot_is_right(slot_d);
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2s_master.sv
// i2s_master: I2S bus master, TX/RX shift registers and word handshakes.
// Define I2S_LOOPBACK_EN to add the loopback port (RX samples internal sdout).
module i2s_master
    import i2s_pkg::*;
#(
    parameter int BCLK_DIV = 4
) (
    input  logic bus_clk,
    input  logic bus_rst_n,
    input  logic enable,
`ifdef I2S_LOOPBACK_EN
    input  logic loopback,
`endif
    i2s_if.slave bus,
    output logic i2s_bclk,
    output logic i2s_lrclk,
    output logic i2s_sdout,
    input  logic i2s_sdin
);

    logic                  rise;
    logic                  fall;
    slot_t                 slot;
    logic                  sdin_reg;
    logic                  sdout_q;
    logic                  rx_bit;
    logic                  rx_primed;
    logic                  load;
    logic                  underrun_q;
    logic                  rx_valid_q;
    frame_t                rx_data_q;
    frame_t                tx_word;
    logic [FRAME_BITS-2:0] txsh;
    logic [FRAME_BITS-2:0] rxsh;

    i2s_clkgen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_clkgen (
        .bus_clk   (bus_clk),
        .bus_rst_n (bus_rst_n),
        .enable    (enable),
        .bclk      (i2s_bclk),
        .lrclk     (i2s_lrclk),
        .rise      (rise),
        .fall      (fall),
        .slot      (slot)
    );

    assign load    = enable && fall && (slot == slot_t'(SLOT_LEFT_MSB));
    assign tx_word = bus.tx_valid ? bus.tx_data : '0;

`ifdef I2S_LOOPBACK_EN
    assign rx_bit = loopback ? sdout_q : sdin_reg;
`else
    assign rx_bit = sdin_reg;
`endif

    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            sdin_reg <= 1'b0;
        end else begin
            sdin_reg <= i2s_sdin;
        end
    end

    // Launch on falling BCLK; the word MSB goes out one slot after lrclk
    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            sdout_q    <= 1'b0;
            txsh       <= '0;
            underrun_q <= 1'b0;
        end else if (!enable) begin
            sdout_q    <= 1'b0;
            txsh       <= '0;
            underrun_q <= 1'b0;
        end else if (load) begin
            sdout_q <= tx_word[FRAME_BITS-1];
            txsh    <= tx_word[FRAME_BITS-2:0];
            if (!bus.tx_valid) begin
                underrun_q <= 1'b1;
            end
        end else if (fall) begin
            sdout_q <= txsh[FRAME_BITS-2];
            txsh    <= {txsh[FRAME_BITS-3:0], 1'b0};
        end
    end

    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            rxsh       <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_primed  <= 1'b0;
        end else if (!enable) begin
            rxsh       <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_primed  <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (rise) begin
                rxsh <= {rxsh[FRAME_BITS-3:0], rx_bit};
                if (slot == slot_t'(SLOT_LAST)) begin
                    rx_data_q  <= {rxsh, rx_bit};
                    rx_valid_q <= rx_primed;
                end
                if (slot == slot_t'(SLOT_LEFT_MSB)) begin
                    rx_primed <= 1'b1;
                end
            end
        end
    end

    assign bus.tx_ready    = load;
    assign bus.tx_underrun = underrun_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign i2s_sdout       = sdout_q;

endmodule

// File: tb/tb_i2s_master.sv
// tb_i2s_master: directed bench for i2s_master with a tx/rx word scoreboard.
// A second instance with BCLK_DIV=2 covers the fast-divider reset case.
module tb_i2s_master;
    import i2s_pkg::*;

    localparam int DIV   = 4;
    localparam int FRAME = 64 * DIV;

    logic bus_clk   = 1'b0;
    logic bus_rst_n = 1'b0;
    logic enable    = 1'b0;
    logic i2s_sdin  = 1'b0;
    logic bclk, lrclk, sdout;
    logic bclk2, lrclk2, sdout2;
`ifdef I2S_LOOPBACK_EN
    logic loopback = 1'b0;
`endif

    i2s_if bus ();
    i2s_if bus2 ();

    i2s_master #(.BCLK_DIV(DIV)) dut (
`ifdef I2S_LOOPBACK_EN
        .loopback  (loopback),
`endif
        .bus_clk   (bus_clk),
        .bus_rst_n (bus_rst_n),
        .enable    (enable),
        .bus       (bus),
        .i2s_bclk  (bclk),
        .i2s_lrclk (lrclk),
        .i2s_sdout (sdout),
        .i2s_sdin  (i2s_sdin)
    );

    i2s_master #(.BCLK_DIV(2)) dut2 (
`ifdef I2S_LOOPBACK_EN
        .loopback  (1'b0),
`endif
        .bus_clk   (bus_clk),
        .bus_rst_n (bus_rst_n),
        .enable    (enable),
        .bus       (bus2),
        .i2s_bclk  (bclk2),
        .i2s_lrclk (lrclk2),
        .i2s_sdout (sdout2),
        .i2s_sdin  (1'b0)
    );

    always #5 bus_clk = ~bus_clk;

    int n_cmp = 0;
    int n_mis = 0;

    int cyc = 0, last_rise = 0, bclk_per = 0;
    int last_lr_fall = 0, lr_per = 0, lr_low = 0;
    int tx_pulses = 0, rx_pulses = 0, sb_words = 0;
    logic bclk_q = 1'b0, lrclk_q = 1'b1, lr_at_rise = 1'b1;
    logic rdy_q = 1'b0, msb_q = 1'b0;
    bit lb_mode = 1'b0;
    logic [31:0] rx_word = '0;
    frame_t tx_exp;
    frame_t txq[$];
    frame_t rxq[$];
    frame_t sd_words[4] = '{32'h1234_8001, 32'h8000_0001,
                            32'hFFFF_0000, 32'h0000_FFFF};

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // I2S receiver on sdout plus handshake scoreboard
    always @(negedge bus_clk) begin
        cyc++;
        if (rdy_q) check("first_bit", 32'(sdout), 32'(msb_q));
        rdy_q = bus.tx_ready;
        if (bus.tx_ready) begin
            tx_exp = bus.tx_valid ? bus.tx_data : '0;
            tx_pulses++;
            txq.push_back(tx_exp);
            msb_q = tx_exp[31];
            if (lb_mode) rxq.push_back(tx_exp);
        end
        if (bclk && !bclk_q) begin
            bclk_per  = cyc - last_rise;
            last_rise = cyc;
            rx_word   = {rx_word[30:0], sdout};
            if (!lrclk && lr_at_rise) begin
                if (txq.size() > 0) begin
                    check("sdout_word", rx_word, txq.pop_front());
                    sb_words++;
                end else begin
                    check("slot0_first", 32'(sdout), 32'd0);
                end
            end
            lr_at_rise = lrclk;
        end
        if (!lrclk && lrclk_q) begin
            lr_per       = cyc - last_lr_fall;
            last_lr_fall = cyc;
        end
        if (lrclk && !lrclk_q) lr_low = cyc - last_lr_fall;
        if (bus.rx_valid) begin
            rx_pulses++;
            if (rxq.size() > 0) check("rx_data", bus.rx_data, rxq.pop_front());
        end
        bclk_q  = bclk;
        lrclk_q = lrclk;
    end

    task automatic flush();
        txq.delete();
        rxq.delete();
        lr_at_rise = 1'b1;
        rdy_q      = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_bclk"},     32'(bclk),            32'd0);
        check({tag, "_lrclk"},    32'(lrclk),           32'd1);
        check({tag, "_sdout"},    32'(sdout),           32'd0);
        check({tag, "_tx_ready"}, 32'(bus.tx_ready),    32'd0);
        check({tag, "_rx_valid"}, 32'(bus.rx_valid),    32'd0);
        check({tag, "_rx_data"},  bus.rx_data,          32'd0);
        check({tag, "_underrun"}, 32'(bus.tx_underrun), 32'd0);
    endtask

    task automatic first_rise(input string tag, input int exp);
        int n = 0;
        do begin
            @(negedge bus_clk);
            n++;
        end while (!bclk && n < 40);
        check(tag, 32'(n), 32'(exp));
    endtask

    // I2S transmitter on sdin: MSB in the slot after the lrclk fall
    task automatic drive_sdin(input int nfalls);
        logic   prev_b  = 1'b0;
        logic   prev_lr = 1'b1;
        frame_t sh      = '0;
        int idx = 0, k = 0, falls = 0, guard = 0;
        while (falls < nfalls && guard < nfalls * 2 * DIV + 64) begin
            @(negedge bus_clk);
            guard++;
            if (prev_b && !bclk) begin
                falls++;
                if (!lrclk && prev_lr) idx = 0;
                else idx++;
                prev_lr = lrclk;
                if (idx == 1) begin
                    sh = sd_words[k % 4];
                    rxq.push_back(sh);
                    k++;
                end
                i2s_sdin = sh[31];
                sh = sh << 1;
            end
            prev_b = bclk;
        end
        check("sdin_falls", 32'(falls), 32'(nfalls));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        int p0, w0, r0, n, n1, n2, nl2;
        bus.tx_data   = 32'hA5A5_0F0F;
        bus.tx_valid  = 1'b1;
        bus2.tx_data  = 32'h5555_AAAA;
        bus2.tx_valid = 1'b1;

        // reset and idle
        repeat (3) @(negedge bus_clk);
        bus_rst_n = 1'b1;
        repeat (4) @(negedge bus_clk);
        check_idle("rst");
        repeat (20) @(negedge bus_clk);
        check("idle_hold_lrclk", 32'(lrclk), 32'd1);

        // clocks and held-valid tx
        p0 = tx_pulses;
        w0 = sb_words;
        enable = 1'b1;
        first_rise("first_rise", DIV);
        repeat (3 * FRAME - DIV) @(negedge bus_clk);
        check("bclk_period", 32'(bclk_per), 32'd8);
        check("lrclk_period", 32'(lr_per), 32'd256);
        check("lrclk_low", 32'(lr_low), 32'd128);
        check("tx_ready_pulses", 32'(tx_pulses - p0), 32'd3);
        check("tx_words", 32'(sb_words - w0), 32'd2);
        check("no_underrun", 32'(bus.tx_underrun), 32'd0);
        enable = 1'b0;
        @(negedge bus_clk);
        check_idle("dis1");

        // underrun
        flush();
        bus.tx_valid = 1'b0;
        enable = 1'b1;
        repeat (300) @(negedge bus_clk);
        check("underrun_set", 32'(bus.tx_underrun), 32'd1);
        bus.tx_data  = 32'h3C3C_C3C3;
        bus.tx_valid = 1'b1;
        repeat (600) @(negedge bus_clk);
        check("underrun_sticky", 32'(bus.tx_underrun), 32'd1);
        enable = 1'b0;
        @(negedge bus_clk);
        check_idle("dis2");

        // external sdin capture
        flush();
        bus.tx_data = 32'h0F0F_F0F0;
        r0 = rx_pulses;
        enable = 1'b1;
        drive_sdin(98);
        check("rx_valid_count", 32'(rx_pulses - r0), 32'd3);
        check("rx_pending", 32'(rxq.size()), 32'd1);
        check("rx_data_held", bus.rx_data, sd_words[2]);
        enable = 1'b0;
        i2s_sdin = 1'b0;
        @(negedge bus_clk);
        flush();

`ifdef I2S_LOOPBACK_EN
        loopback = 1'b1;
        lb_mode = 1'b1;
        bus.tx_data = 32'hDEAD_BEEF;
        r0 = rx_pulses;
        enable = 1'b1;
        repeat (3 * FRAME) @(negedge bus_clk);
        check("lb_rx_count", 32'(rx_pulses - r0), 32'd2);
        check("lb_rx_data", bus.rx_data, 32'hDEAD_BEEF);
        enable = 1'b0;
        @(negedge bus_clk);
        lb_mode = 1'b0;
        loopback = 1'b0;
        flush();
`endif

        // enable low at slot 9
        bus.tx_data = 32'hFFFF_FFFF;
        enable = 1'b1;
        repeat (84) @(negedge bus_clk);
        check("slot9_sdout", 32'(sdout), 32'd1);
        check("slot9_lrclk", 32'(lrclk), 32'd0);
        enable = 1'b0;
        @(negedge bus_clk);
        check_idle("slot9_off");
        flush();
        w0 = sb_words;
        enable = 1'b1;
        first_rise("restart_rise", DIV);
        repeat (2 * FRAME - DIV) @(negedge bus_clk);
        check("restart_words", 32'(sb_words - w0), 32'd1);

        // async reset mid-frame
        @(posedge bus_clk);
        #2 bus_rst_n = 1'b0;
        #1;
        check_idle("async_rst");
        check("rst2_bclk", 32'(bclk2), 32'd0);
        check("rst2_lrclk", 32'(lrclk2), 32'd1);
        check("rst2_sdout", 32'(sdout2), 32'd0);
        @(negedge bus_clk);
        flush();
        w0 = sb_words;
        bus_rst_n = 1'b1;
        n = 0; n1 = 0; n2 = 0; nl2 = 0;
        while (n < 40 && (n1 == 0 || n2 == 0 || nl2 == 0)) begin
            @(negedge bus_clk);
            n++;
            if (bclk && n1 == 0) n1 = n;
            if (bclk2 && n2 == 0) n2 = n;
            if (!lrclk2 && nl2 == 0) nl2 = n;
        end
        check("rst_rise", 32'(n1), 32'd4);
        check("rst2_rise", 32'(n2), 32'd2);
        check("rst2_lrclk_fall", 32'(nl2), 32'd4);
        repeat (2 * FRAME - n) @(negedge bus_clk);
        check("rst_words", 32'(sb_words - w0), 32'd1);
        enable = 1'b0;
        @(negedge bus_clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
